// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO with flush; head is presented as zero when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A push into a full queue is legal when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // NOTE: the storage array has no reset; occupancy comes from r_count and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a queue, and redirect handling that drains stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [OW-1:0]   r_outstanding;
  logic [OW-1:0]   w_outstanding_nxt;
  logic [OW-1:0]   r_discard_cnt;
  logic [OW-1:0]   w_discard_nxt;
  logic            r_run;
  logic            w_credit_ok;
  logic            w_req_hs;
  logic            w_rsp_take;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_rsp_pc;
  logic            w_q_valid;
  logic [CW-1:0]   w_q_count;
  fetch_entry_t    w_q_head;
  fetch_entry_t    w_push_entry;

  // Every outstanding request must have a guaranteed queue slot for its response.
  assign w_credit_ok = (32'(r_outstanding) < MAX_OUT) &&
                       ((32'(r_outstanding) + 32'(w_q_count)) < QDEPTH);

  assign imem_req_valid = r_run && (r_state == FETCH) && w_credit_ok;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_hs       = imem_req_valid && imem_req_ready;
  assign w_rsp_take     = imem_rsp_valid && (r_outstanding != '0);
  assign w_push         = w_rsp_take && (r_state == FETCH) && !redirect_valid;
  assign w_pop          = w_q_valid && inst_ready;

  // In FETCH all outstanding requests are consecutive words ending just below fetch_pc.
  assign w_rsp_pc           = r_fetch_pc - (XLEN'(r_outstanding) << 2);
  assign w_push_entry.pc    = w_rsp_pc;
  assign w_push_entry.inst  = imem_rsp_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding + OW'(w_req_hs) - OW'(w_rsp_take);
    w_discard_nxt     = r_discard_cnt;
    if (w_req_hs) w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
    if ((r_state == DRAIN) && w_rsp_take) w_discard_nxt = r_discard_cnt - OW'(1);
    if (redirect_valid) begin
      w_fetch_pc_nxt = word_align(redirect_pc);
      w_discard_nxt  = w_outstanding_nxt;
    end
    w_state_nxt = (w_discard_nxt != '0) ? DRAIN : FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_run         <= 1'b1;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard_cnt <= w_discard_nxt;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (redirect_valid),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_valid      (w_q_valid),
    .o_head       (w_q_head),
    .o_count      (w_q_count)
  );

  assign inst_valid = w_q_valid;
  assign inst_data  = w_q_head.inst;
  assign inst_pc    = w_q_head.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 Parameter MAX_OUT, default 2, maximum outstanding memory requests.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 redirect_valid  in  1  branch/exception redirect strobe.
REQ-008 redirect_pc  in  32  new fetch address.
REQ-009 imem_req_valid  out  1  fetch request valid.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_req_addr  out  32  word-aligned fetch address.
REQ-012 imem_rsp_valid  in  1  in-order response valid, never back-pressured.
REQ-013 imem_rsp_data  in  32  fetched instruction word.
REQ-014 inst_valid  out  1  instruction available to decode.
REQ-015 inst_ready  in  1  decode accepts instruction.
REQ-016 inst_data  out  32  instruction word.
REQ-017 inst_pc  out  32  address of inst_data.

Function
REQ-018 Request handshake occurs when imem_req_valid and imem_req_ready are both 1; fetch_pc then advances by 4, wrapping 0xFFFF_FFFC to 0x0000_0000.
REQ-019 imem_req_valid SHALL assert only in state FETCH when outstanding < MAX_OUT and outstanding + queue_count < QDEPTH (credit rule guaranteeing response space).
REQ-020 Once asserted, imem_req_valid and imem_req_addr SHALL hold stable until handshake, except on redirect.
REQ-021 Each accepted response SHALL be written to the queue with its pc; inst_valid asserts the cycle after capture (1-cycle latency, no bypass).
REQ-022 Queue pops on inst_valid && inst_ready; simultaneous push and pop when full-minus-credit SHALL be legal; count never exceeds QDEPTH.
REQ-023 FSM states: FETCH, DRAIN.
REQ-024 On redirect_valid: fetch_pc <= {redirect_pc[31:2],2'b00}, queue flushed, discard_cnt <= outstanding after this cycle's events (including a request handshake in the same cycle, minus a response in the same cycle); next state DRAIN if that count > 0, else FETCH.
REQ-025 A response arriving in the redirect cycle SHALL be dropped.
REQ-026 In DRAIN, no requests issue; each response decrements discard_cnt and is dropped; at zero, return to FETCH next cycle.
REQ-027 Redirect during DRAIN SHALL reload fetch_pc and keep discarding the remaining count.
REQ-028 A pop coinciding with redirect completes to decode; the queue is still fully flushed.
REQ-029 A response with outstanding == 0 is a protocol error and SHALL be ignored.

Reset
REQ-030 While rst_n = 0: state FETCH, fetch_pc = RESET_PC, outstanding = 0, discard_cnt = 0, queue empty, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-031 First imem_req_valid SHALL assert in the first cycle after rst_n deassertion, with address RESET_PC.
REQ-032 Reset mid-operation SHALL abandon all in-flight requests; the memory side is reset by the same rst_n.

Structure
REQ-033 Shared package fetch_pkg holds RESET_PC default, word width 32, and the queue entry struct {pc, inst}.
REQ-034 Queue is sub-module fetch_queue (synchronous FIFO, flush input, count output); FSM and credit logic stay in fetch_unit.

Verification
REQ-035 Reset, imem_req_ready=1, 1-cycle memory, inst_ready=1 -> addresses 0x0,0x4,0x8...; inst_pc stream matches, one instruction per cycle steady state.
REQ-036 inst_ready=0 with QDEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 until a pop.
REQ-037 imem_req_ready=0 for 5 cycles -> imem_req_addr held at 0x8, valid held high.
REQ-038 Two outstanding, redirect to 0x1002 -> both responses dropped, next request address 0x1000, first inst_pc 0x1000.
REQ-039 Redirect in same cycle as request handshake and response -> discard_cnt correct, no stale instruction reaches decode.
REQ-040 fetch_pc 0xFFFF_FFFC -> next request address 0x0000_0000; rst_n asserted mid-stream -> outputs reach REQ-030 values immediately.
